// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment check for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            SZ_WORD: misaligned = |a;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and memory req/ack signals of the load/store unit.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc
    );

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables / replication and load extraction / extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_addr +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_ld    = 32'd0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_ld    = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_ld    = {{16{i_sign & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_ld    = i_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one access at a time, alignment check, req/ack memory port.
// Optional ack timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);
    state_e      r_state, w_next;
    logic        r_we, r_sign, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_pc, r_rdata;
    logic        w_accept, w_bad, w_in_req, w_in_resp, w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld;

    assign w_accept  = bus.req_valid & (r_state == ST_IDLE);
    assign w_bad     = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
    logic [CW-1:0] r_cnt;

    // Expiry is taken on the edge the counter would reach TIMEOUT; a same-cycle ack wins.
    assign w_expire = w_in_req & ~bus.mem_ack & (r_cnt == LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        r_cnt <= '0;
        else if (!w_in_req)              r_cnt <= '0;
        else if (!bus.mem_ack)           r_cnt <= r_cnt + 1'b1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_expire = 1'b0;
`endif

    lsu_lane u_lane (
        .i_addr  (r_addr[1:0]),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .i_wdata (r_wdata),
        .i_rdata (bus.mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ld    (w_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_bad ? ST_RESP : ST_REQ;
            ST_REQ:  if (bus.mem_ack || w_expire) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_sign  <= bus.req_sign;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_pc    <= bus.req_pc;
            r_rdata <= 32'd0;
            r_err   <= w_bad;
        end else if (w_in_req && bus.mem_ack) begin
            r_rdata <= r_we ? 32'd0 : w_ld;
            r_err   <= 1'b0;
        end else if (w_expire) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = w_in_resp;
    assign bus.resp_rdata = w_in_resp ? r_rdata : 32'd0;
    assign bus.resp_err   = w_in_resp & r_err;

    assign bus.mem_req    = w_in_req;
    assign bus.mem_we     = w_in_req & r_we;
    assign bus.mem_be     = w_in_req ? w_be : 4'b0000;
    assign bus.mem_addr   = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_wdata  = w_in_req ? w_wdata : 32'd0;
    assign bus.mem_pc     = w_in_req ? r_pc : 32'd0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses, monitor checks every response.
module tb_lsu_ctrl;
    localparam int TO = `ifdef LSU_TIMEOUT_EN 4 `else 255 `endif;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", {31'd0, bus.resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rd);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            end
        end else begin
            chk("idle_rdata", bus.resp_rdata, 32'd0);
            chk("idle_err", {31'd0, bus.resp_err}, 32'd0);
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_sign  = sg;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_pc    = {16'hC0DE, addr[15:0]};
    endtask

    task automatic access(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                          input int dly, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic eerr);
        exp_t e;
        issue(we, sz, sg, addr, wd);
        chk({nm, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        e.rd = erd;
        e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (eerr) begin
            chk({nm, "_nomemreq"}, {31'd0, bus.mem_req}, 32'd0);
            chk({nm, "_errlat"}, {31'd0, bus.resp_valid}, 32'd1);
        end else begin
            for (int k = 0; k <= dly; k++) begin
                chk({nm, "_memreq"}, {31'd0, bus.mem_req}, 32'd1);
                chk({nm, "_we"}, {31'd0, bus.mem_we}, {31'd0, we});
                chk({nm, "_be"}, {28'd0, bus.mem_be}, {28'd0, ebe});
                chk({nm, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                chk({nm, "_wdata"}, bus.mem_wdata, ewd);
                chk({nm, "_pc"}, bus.mem_pc, {16'hC0DE, addr[15:0]});
                chk({nm, "_early"}, {31'd0, bus.resp_valid}, 32'd0);
                if (k == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdat;
                end
                @(posedge clk); #1;
            end
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'd0;
            chk({nm, "_resplat"}, {31'd0, bus.resp_valid}, 32'd1);
            chk({nm, "_reqdrop"}, {31'd0, bus.mem_req}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_sign = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_pc = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        //      name     we    size   sg    addr          wdata         mem_rdata     dly be       wdata exp     rdata exp     err
        access("sw",    1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h1111_1111, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0);
        access("lb",    1'b0, 2'b00, 1'b1, 32'h0000_0007, 32'h0,         32'h80FF_1234, 0, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
        access("lbu",   1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0,         32'h80FF_1234, 0, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
        access("sh",    1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 32'h0,         0, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0);
        access("lw_mis",1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1);
        access("lh_dly",1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 3, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
        access("lhu",   1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_F00F, 1, 4'b0011, 32'h0,         32'h0000_F00F, 1'b0);
        access("sb",    1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h0,         0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0);
        access("ill",   1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1);
        access("sh_mis",1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_1234, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1'b1);
        access("lb1",   1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0,         32'h0000_007F, 1'b0);

        // Reset while waiting for ack: no response, later ack ignored.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstreq_memreq", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstreq_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rstreq_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstreq_addr", bus.mem_addr, 32'd0);
        chk("rstreq_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("rstreq_idle", {31'd0, bus.req_ready}, 32'd1);
        chk("rstreq_noreq", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            int   cnt;
            issue(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0);
            e.rd = 32'h0;
            e.err = 1'b1;
            sb.push_back(e);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            cnt = 0;
            while (bus.mem_req === 1'b1 && cnt < 20) begin
                cnt++;
                @(posedge clk); #1;
            end
            chk("to_cycles", cnt, TO);
            chk("to_resp", {31'd0, bus.resp_valid}, 32'd1);
            @(posedge clk); #1;
        end
`endif

        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator between the CPU datapath and the data memory. It accepts one byte, halfword or word access at a time from the pipeline and checks alignment. It drives a req/ack word-wide memory port with byte enables, then returns sign- or zero-extended load data with a one-cycle response pulse. The datapath stalls on `req_ready`=0.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ack`; used only when `LSU_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  access request from the pipeline.
- `req_ready`  out  1  high only in IDLE; the request is accepted when `req_valid`&`req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_sign`  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_pc`  in  32  PC of the instruction; forwarded for memory trace.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned/illegal access, or timeout.
- `mem_req`  out  1  memory request; held high until acknowledged.
- `mem_we`  out  1  write strobe.
- `mem_be`  out  4  byte enables; bit i covers bits [8i+7:8i].
- `mem_addr`  out  32  word address; bits [1:0] are always 00.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_pc`  out  32  registered `req_pc`.
- `mem_ack`  in  1  memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  full word read from memory.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - REQ: `mem_req`=1.
  - RESP: `resp_valid`=1.
- IDLE on accept:
  - Aligned request: register all fields, go to REQ.
  - Misaligned or illegal request: go to RESP with `resp_err`=1. No memory access is made.
- Misaligned means: half with addr[0]=1; word with addr[1:0]≠0; any access with size 11.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001 << addr[1:0].
- `mem_wdata`:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- REQ: all `mem_*` outputs stay stable until `mem_ack`=1 at a rising edge. On that edge, capture the extended load data and go to RESP.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend to 32 bits per the registered `req_sign`.
- RESP: one cycle, then IDLE. A new request can be accepted in the cycle after RESP.
- `mem_ack` outside REQ is ignored.
- Memory outputs are 0 outside REQ.

## Timing
- Reset (async, `rst`=0): state goes to IDLE. All outputs are 0 except `req_ready`=1. Any in-flight transaction is dropped with no response.
- Latency: accept at edge N, `mem_req` high during cycle N+1. If `mem_ack` is high in N+1, `resp_valid` is high in N+2. Each additional wait cycle adds 1.
- Error path: accept at edge N, `resp_valid`&`resp_err` high in N+1.
- Throughput: at most one access per 3 cycles.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1, and are 0 otherwise.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A wait counter of width $clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT, drop `mem_req` and go to RESP with `resp_err`=1, `resp_rdata`=0.
  - An ack in the same cycle as expiry wins: normal response.
- `LSU_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely.

## Structure
- Package `lsu_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the `misaligned()` function.
- Sub-module `lsu_lane` (combinational):
  - from addr/size/wdata, produces be and replicated wdata;
  - from rdata/addr/size/sign, produces the extended load value.
- `lsu_ctrl` holds the FSM, the request registers and the optional timeout counter.

## Test plan
- sw addr 0x0000_0008 data 0xDEADBEEF, ack in first REQ cycle:
  - in REQ: mem_be=1111, mem_addr=0x8, mem_wdata=0xDEADBEEF;
  - resp_valid 2 cycles after accept, rdata 0, err 0.
- lb sign, addr 0x0000_0007, mem_rdata 0x80FF_1234 -> mem_be=1000, resp_rdata=0xFFFF_FF80. Repeat as lbu -> 0x0000_0080.
- sh addr 0x2 data 0x0000_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x0.
- lw addr 0x5 -> no mem_req ever asserted; resp_valid&resp_err one cycle after accept.
- Ack delayed 3 cycles -> mem_* stable for 4 cycles; resp 5 cycles after accept. With `LSU_TIMEOUT_EN` and TIMEOUT=4 and no ack -> resp_err at timeout.
- rst low during REQ -> outputs 0 immediately, req_ready=1, no resp_valid; a later ack is ignored.
